// File: rtl/cmp_result_monitor.sv
// Consumer of (A, B, S/E/G) comparator tuples. It keeps saturating outcome counts, the running
// max of A, and the length of the current A>B run, and raises an alarm when that run is too long.
module cmp_result_monitor #(
  parameter int CNT_W      = 8,
  parameter int RUN_THRESH = 4,
  localparam int RUN_W     = $clog2(RUN_THRESH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_lt,
  input  logic             in_eq,
  input  logic             in_gt,
  input  logic             clr,
  input  logic             alarm_ack,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [3:0]       max_a,
  output logic [RUN_W-1:0] run_len,
  output logic             alarm,
  output logic             flag_err
);

  typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

  state_t     state, state_nxt;
  logic       xfer;
  logic       legal;
  logic       run_hit;
  logic [2:0] flags;

  // in_b is carried for debug only; the comparator flags already encode the relation.
  logic       unused_b;
  assign unused_b = ^in_b;

  assign flags    = {in_lt, in_eq, in_gt};
  assign legal    = flags inside {3'b001, 3'b010, 3'b100};
  assign in_ready = ~rst & (state != ALARM);
  assign xfer     = in_valid & in_ready;
  assign run_hit  = xfer & legal & in_gt & (run_len == RUN_W'(RUN_THRESH - 1));
  assign alarm    = (state == ALARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable gets its default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer)      state_nxt = run_hit ? ALARM : TRACK;
      TRACK:   if (run_hit)   state_nxt = ALARM;
      ALARM:   if (alarm_ack) state_nxt = TRACK;
      default:                state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_cnt   <= '0;
      eq_cnt   <= '0;
      gt_cnt   <= '0;
      max_a    <= '0;
      run_len  <= '0;
      flag_err <= 1'b0;
    end else if (clr) begin
      // clr wins over a same-cycle transfer: the tuple is consumed but dropped.
      lt_cnt   <= '0;
      eq_cnt   <= '0;
      gt_cnt   <= '0;
      max_a    <= '0;
      run_len  <= '0;
      flag_err <= 1'b0;
    end else if (state == ALARM) begin
      if (alarm_ack) run_len <= '0;
    end else if (xfer) begin
      if (!legal) begin
        flag_err <= 1'b1;
      end else begin
        if (in_lt && lt_cnt != '1) lt_cnt <= lt_cnt + 1'b1;
        if (in_eq && eq_cnt != '1) eq_cnt <= eq_cnt + 1'b1;
        if (in_gt && gt_cnt != '1) gt_cnt <= gt_cnt + 1'b1;
        if (in_a > max_a)          max_a  <= in_a;
        // Reaching RUN_THRESH enters ALARM, which blocks transfers, so run_len cannot overshoot.
        run_len <= in_gt ? run_len + 1'b1 : '0;
      end
    end
  end

endmodule
